// File: rtl/prio_pkg.sv
// Shared constants, FSM state type and a constant-function clog2 for the
// priority encoder / arbiter.
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Usable in parameter expressions on tools without $clog2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pick: rotate requests so that index last-1 sits on top, take the
// highest set bit, then rotate the winner back to an absolute index.
module prio_pick
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    input  logic         mode,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot,
    output logic         any
);

    logic [W-1:0] base;
    logic [N-1:0] rot;
    logic [W-1:0] sel;
    logic [W:0]   code_sum;

    // Fixed priority is simply the round-robin scan with a zero rotation.
    assign base = mode ? last : '0;

    // Rotated bit gi holds req[(gi + base) mod N]; base < N keeps one subtraction enough.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [W:0]   src_sum;
        logic [W-1:0] src;
        assign src_sum = {1'b0, base} + (W+1)'(gi);
        assign src     = (src_sum >= (W+1)'(N)) ? W'(src_sum - (W+1)'(N)) : src_sum[W-1:0];
        assign rot[gi] = req[src];
    end

    always_comb begin
        sel = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                sel = W'(j);
            end
        end
    end

    assign code_sum = {1'b0, sel} + {1'b0, base};
    assign code     = (code_sum >= (W+1)'(N)) ? W'(code_sum - (W+1)'(N)) : code_sum[W-1:0];
    assign any      = |req;
    assign onehot   = any ? (N'(1) << code) : '0;

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority encoder with valid/ready output: a grant is held frozen until
// the consumer accepts it, with one grant per clock when requests keep coming.
module prio_enc_arb
    import prio_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_onehot,
    output logic         busy_any
);

    state_e       state_q;
    logic         valid_q;
    logic [W-1:0] code_q;
    logic [N-1:0] onehot_q;
    logic [W-1:0] last_q;
    logic [W-1:0] last_d;
    logic         accept;

    logic [W-1:0] pick_code;
    logic [N-1:0] pick_onehot;
    logic         pick_any;

    assign accept = valid_q & out_ready;

    // A back-to-back reload must already see the grant being accepted on this edge.
    assign last_d = accept ? code_q : last_q;

    prio_pick #(
        .N(N)
    ) u_pick (
        .req   (req),
        .last  (last_d),
        .mode  (MODE == MODE_RR),
        .code  (pick_code),
        .onehot(pick_onehot),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            code_q   <= '0;
            onehot_q <= '0;
            last_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        valid_q  <= 1'b1;
                        code_q   <= pick_code;
                        onehot_q <= pick_onehot;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (out_ready) begin
                        last_q <= last_d;
                        if (pick_any) begin
                            code_q   <= pick_code;
                            onehot_q <= pick_onehot;
                        end else begin
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q  <= 1'b0;
                    onehot_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_code   = code_q;
    assign out_onehot = onehot_q;
    assign busy_any   = |req;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed-vector bench for prio_enc_arb: fixed and round-robin instances,
// a non-power-of-two width, backpressure and asynchronous reset.
module tb_prio_enc_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] req4 = '0;
    logic       rdy4 = 1'b0;
    logic       v4;
    logic [1:0] c4;
    logic [3:0] o4;
    logic       b4;

    logic [7:0] req8r = '0;
    logic       rdy8r = 1'b0;
    logic       v8r;
    logic [2:0] c8r;
    logic [7:0] o8r;
    logic       b8r;

    logic [7:0] req8f = '0;
    logic       rdy8f = 1'b0;
    logic       v8f;
    logic [2:0] c8f;
    logic [7:0] o8f;
    logic       b8f;

    logic [4:0] req5 = '0;
    logic       rdy5 = 1'b0;
    logic       v5;
    logic [2:0] c5;
    logic [4:0] o5;
    logic       b5;

    int n_checks = 0;
    int n_fail   = 0;

    prio_enc_arb #(.N(4), .MODE(0)) u_f4 (
        .clk(clk), .reset(reset), .req(req4), .out_ready(rdy4),
        .out_valid(v4), .out_code(c4), .out_onehot(o4), .busy_any(b4)
    );
    prio_enc_arb #(.N(8), .MODE(1)) u_r8 (
        .clk(clk), .reset(reset), .req(req8r), .out_ready(rdy8r),
        .out_valid(v8r), .out_code(c8r), .out_onehot(o8r), .busy_any(b8r)
    );
    prio_enc_arb #(.N(8), .MODE(0)) u_f8 (
        .clk(clk), .reset(reset), .req(req8f), .out_ready(rdy8f),
        .out_valid(v8f), .out_code(c8f), .out_onehot(o8f), .busy_any(b8f)
    );
    prio_enc_arb #(.N(5), .MODE(1)) u_r5 (
        .clk(clk), .reset(reset), .req(req5), .out_ready(rdy5),
        .out_valid(v5), .out_code(c5), .out_onehot(o5), .busy_any(b5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req4 = '0; req8r = '0; req8f = '0; req5 = '0;
        rdy4 = 1'b0; rdy8r = 1'b0; rdy8f = 1'b0; rdy5 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({v4, c4, o4} !== 7'd0) begin
            n_fail++; $display("FAIL reset_f4 got v=%b code=%0d onehot=%b want 0/0/0", v4, c4, o4);
        end
        n_checks++;
        if ({v8r, c8r, o8r} !== 12'd0) begin
            n_fail++; $display("FAIL reset_r8 got v=%b code=%0d onehot=%b want 0/0/0", v8r, c8r, o8r);
        end
        n_checks++;
        if ({v5, c5, o5} !== 9'd0) begin
            n_fail++; $display("FAIL reset_r5 got v=%b code=%0d onehot=%b want 0/0/0", v5, c5, o5);
        end
        $display("reset: f4 v=%b r8 v=%b r5 v=%b", v4, v8r, v5);
    endtask

    task automatic test_fixed_basic;
        req4 = 4'b1010; rdy4 = 1'b1;
        #1;
        n_checks++;
        if (b4 !== 1'b1) begin
            n_fail++; $display("FAIL busy_any got %b want 1", b4);
        end
        tick();
        $display("fixed_basic: v=%b code=%0d onehot=%b", v4, c4, o4);
        n_checks++;
        if (v4 !== 1'b1 || c4 !== 2'd3 || o4 !== 4'b1000) begin
            n_fail++; $display("FAIL fixed_basic got v=%b code=%0d onehot=%b want 1/3/1000", v4, c4, o4);
        end
        req4 = '0;
        tick();
        n_checks++;
        if (v4 !== 1'b0 || o4 !== 4'b0000) begin
            n_fail++; $display("FAIL fixed_to_idle got v=%b onehot=%b want 0/0000", v4, o4);
        end
    endtask

    task automatic test_backpressure;
        req4 = 4'b0001; rdy4 = 1'b0;
        tick();
        n_checks++;
        if (v4 !== 1'b1 || c4 !== 2'd0 || o4 !== 4'b0001) begin
            n_fail++; $display("FAIL bp_first got v=%b code=%0d onehot=%b want 1/0/0001", v4, c4, o4);
        end
        req4 = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("backpressure hold %0d: v=%b code=%0d onehot=%b", i, v4, c4, o4);
            n_checks++;
            if (v4 !== 1'b1 || c4 !== 2'd0 || o4 !== 4'b0001) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b code=%0d onehot=%b want 1/0/0001", i, v4, c4, o4);
            end
        end
        rdy4 = 1'b1;
        tick();
        n_checks++;
        if (v4 !== 1'b1 || c4 !== 2'd2 || o4 !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release got v=%b code=%0d onehot=%b want 1/2/0100", v4, c4, o4);
        end
        req4 = '0;
        tick();
    endtask

    task automatic test_hold_drop;
        req4 = 4'b1000; rdy4 = 1'b0;
        tick();
        req4 = '0;
        tick();
        $display("hold_drop: v=%b code=%0d onehot=%b busy=%b", v4, c4, o4, b4);
        n_checks++;
        if (v4 !== 1'b1 || c4 !== 2'd3 || o4 !== 4'b1000 || b4 !== 1'b0) begin
            n_fail++; $display("FAIL hold_drop got v=%b code=%0d onehot=%b busy=%b want 1/3/1000/0", v4, c4, o4, b4);
        end
        rdy4 = 1'b1;
        tick();
        n_checks++;
        if (v4 !== 1'b0 || o4 !== 4'b0000) begin
            n_fail++; $display("FAIL hold_drop_idle got v=%b onehot=%b want 0/0000", v4, o4);
        end
    endtask

    task automatic test_idle;
        do_reset();
        rdy4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (v4 !== 1'b0 || c4 !== 2'd0 || o4 !== 4'd0 || b4 !== 1'b0) begin
                n_fail++; $display("FAIL idle%0d got v=%b code=%0d onehot=%b busy=%b want 0/0/0000/0", i, v4, c4, o4, b4);
            end
        end
        $display("idle: 10 clks v=%b code=%0d busy=%b", v4, c4, b4);
        req4 = 4'b0001;
        tick();
        n_checks++;
        if (v4 !== 1'b1 || c4 !== 2'd0) begin
            n_fail++; $display("FAIL idle_then_req got v=%b code=%0d want 1/0", v4, c4);
        end
        req4 = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        int exp_codes[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        logic [7:0] exp_oh;
        do_reset();
        req8r = 8'hFF; rdy8r = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_oh = 8'd1 << exp_codes[i];
            $display("rr_b2b %0d: v=%b code=%0d onehot=%b", i, v8r, c8r, o8r);
            n_checks++;
            if (v8r !== 1'b1 || c8r !== 3'(exp_codes[i]) || o8r !== exp_oh) begin
                n_fail++; $display("FAIL rr_b2b%0d got v=%b code=%0d onehot=%b want 1/%0d/%b", i, v8r, c8r, o8r, exp_codes[i], exp_oh);
            end
        end
        req8r = '0;
        tick();
    endtask

    task automatic test_rr_vs_fixed;
        logic [2:0] exp_r;
        do_reset();
        req8r = 8'h81; req8f = 8'h81; rdy8r = 1'b1; rdy8f = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_r = (i % 2 == 0) ? 3'd7 : 3'd0;
            $display("rr_vs_fixed %0d: rr=%0d fixed=%0d", i, c8r, c8f);
            n_checks++;
            if (v8r !== 1'b1 || c8r !== exp_r) begin
                n_fail++; $display("FAIL rr_alt%0d got v=%b code=%0d want 1/%0d", i, v8r, c8r, exp_r);
            end
            n_checks++;
            if (v8f !== 1'b1 || c8f !== 3'd7) begin
                n_fail++; $display("FAIL fixed_stay%0d got v=%b code=%0d want 1/7", i, v8f, c8f);
            end
        end
        req8r = '0; req8f = '0;
        tick();
    endtask

    task automatic test_nonpow2;
        int exp_codes[6] = '{4, 3, 2, 1, 0, 4};
        logic [4:0] exp_oh;
        do_reset();
        req5 = 5'b11111; rdy5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_oh = 5'd1 << exp_codes[i];
            $display("nonpow2 %0d: v=%b code=%0d onehot=%b", i, v5, c5, o5);
            n_checks++;
            if (v5 !== 1'b1 || c5 !== 3'(exp_codes[i]) || o5 !== exp_oh) begin
                n_fail++; $display("FAIL nonpow2_%0d got v=%b code=%0d onehot=%b want 1/%0d/%b", i, v5, c5, o5, exp_codes[i], exp_oh);
            end
        end
        req5 = '0;
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        req8r = 8'hFF; rdy8r = 1'b1;
        tick();
        tick();
        tick();
        rdy8r = 1'b0;
        tick();
        n_checks++;
        if (v8r !== 1'b1 || c8r !== 3'd5) begin
            n_fail++; $display("FAIL areset_pre got v=%b code=%0d want 1/5", v8r, c8r);
        end
        reset = 1'b1;
        #1;
        $display("async_reset mid-cycle: v=%b code=%0d onehot=%b", v8r, c8r, o8r);
        n_checks++;
        if (v8r !== 1'b0 || o8r !== 8'd0 || c8r !== 3'd0) begin
            n_fail++; $display("FAIL areset_clear got v=%b code=%0d onehot=%b want 0/0/0", v8r, c8r, o8r);
        end
        #2;
        reset = 1'b0;
        rdy8r = 1'b1;
        tick();
        n_checks++;
        if (v8r !== 1'b1 || c8r !== 3'd7) begin
            n_fail++; $display("FAIL areset_rr_restart got v=%b code=%0d want 1/7", v8r, c8r);
        end
        req8r = '0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed_basic();
        test_backpressure();
        test_hold_drop();
        test_idle();
        test_back_to_back();
        test_rr_vs_fixed();
        test_nonpow2();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
